// File: rtl/ram_arbiter.sv
// Two-master round-robin front end for a single gen_ram instance.
// Decodes byte addresses into the RAM window and routes the one-cycle response back.
module ram_arbiter #(
    parameter int          DP   = 512,
    parameter int          DW   = 32,
    parameter int          MW   = 4,
    parameter int          RAW  = 9,
    parameter logic [31:0] BASE = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           rst,

    input  logic           m0_req,
    input  logic           m0_we,
    input  logic [31:0]    m0_addr,
    input  logic [DW-1:0]  m0_wdata,
    input  logic [MW-1:0]  m0_be,
    output logic           m0_gnt,
    output logic           m0_rvalid,
    output logic [DW-1:0]  m0_rdata,
    output logic           m0_err,

    input  logic           m1_req,
    input  logic           m1_we,
    input  logic [31:0]    m1_addr,
    input  logic [DW-1:0]  m1_wdata,
    input  logic [MW-1:0]  m1_be,
    output logic           m1_gnt,
    output logic           m1_rvalid,
    output logic [DW-1:0]  m1_rdata,
    output logic           m1_err,

    output logic [RAW-1:0] ram_addr,
    output logic [DW-1:0]  ram_data,
    output logic [MW-1:0]  ram_sel,
    output logic           ram_we,
    input  logic [DW-1:0]  ram_rdata
);

    localparam logic [31:0] WIN_BYTES = 32'(DP * 4);

    logic          last_grant;
    logic          rsp_vld;
    logic          rsp_id;
    logic          rsp_err;
    logic          rsp_rd;

    logic          any_gnt;
    logic          sel_we;
    logic [31:0]   sel_addr;
    logic [DW-1:0] sel_wdata;
    logic [MW-1:0] sel_be;
    logic [31:0]   off;
    logic          hit;
    logic          rsp_out;

    // On contention the master that did not win last time gets the slot.
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (!rst) begin
            if (m0_req && m1_req) begin
                m0_gnt = last_grant;
                m1_gnt = !last_grant;
            end else begin
                m0_gnt = m0_req;
                m1_gnt = m1_req;
            end
        end
    end

    assign any_gnt   = m0_gnt || m1_gnt;
    assign sel_we    = m1_gnt ? m1_we    : m0_we;
    assign sel_addr  = m1_gnt ? m1_addr  : m0_addr;
    assign sel_wdata = m1_gnt ? m1_wdata : m0_wdata;
    assign sel_be    = m1_gnt ? m1_be    : m0_be;

    assign off = sel_addr - BASE;
    assign hit = (sel_addr >= BASE) && (off < WIN_BYTES);

    // RAM port stays fully idle unless an in-window access is granted.
    always_comb begin
        ram_addr = '0;
        ram_data = '0;
        ram_sel  = '0;
        ram_we   = 1'b0;
        if (any_gnt && hit) begin
            ram_addr = off[RAW+1:2];
            ram_data = sel_wdata;
            ram_sel  = sel_we ? sel_be : '0;
            ram_we   = sel_we;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_vld    <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_rd     <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            rsp_vld <= any_gnt;
            rsp_id  <= m1_gnt;
            rsp_err <= !hit;
            rsp_rd  <= !sel_we;
            if (any_gnt)
                last_grant <= m1_gnt;
        end
    end

    // Masking with rst drops a response that was in flight when reset arrived.
    assign rsp_out   = rsp_vld && !rst;
    assign m0_rvalid = rsp_out && !rsp_id;
    assign m1_rvalid = rsp_out && rsp_id;
    assign m0_err    = m0_rvalid && rsp_err;
    assign m1_err    = m1_rvalid && rsp_err;
    assign m0_rdata  = (m0_rvalid && rsp_rd && !rsp_err) ? ram_rdata : '0;
    assign m1_rdata  = (m1_rvalid && rsp_rd && !rsp_err) ? ram_rdata : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural RAM + reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ram_arbiter;

    localparam int          DP   = 512;
    localparam int          DW   = 32;
    localparam int          MW   = 4;
    localparam int          RAW  = 9;
    localparam logic [31:0] BASE = 32'h1000_0000;

    logic           clk = 1'b0;
    logic           rst;
    logic           m0_req, m0_we, m1_req, m1_we;
    logic [31:0]    m0_addr, m1_addr;
    logic [DW-1:0]  m0_wdata, m1_wdata;
    logic [MW-1:0]  m0_be, m1_be;
    logic           m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [DW-1:0]  m0_rdata, m1_rdata;
    logic [RAW-1:0] ram_addr;
    logic [DW-1:0]  ram_data, ram_rdata;
    logic [MW-1:0]  ram_sel;
    logic           ram_we;

    int testsRun    = 0;
    int testsFailed = 0;

    ram_arbiter #(.DP(DP), .DW(DW), .MW(MW), .RAW(RAW), .BASE(BASE)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_sel(ram_sel), .ram_we(ram_we),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = !clk;

    // Stand-in for gen_ram: byte-strobed write, registered read.
    logic [DW-1:0] ramMem [DP];
    always @(posedge clk) begin
        if (ram_we)
            for (int b = 0; b < MW; b++)
                if (ram_sel[b]) ramMem[ram_addr][8*b +: 8] <= ram_data[8*b +: 8];
        ram_rdata <= ramMem[ram_addr];
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: memory image, last winner, and the response owed next cycle.
    logic [31:0] refMem [DP];
    int          lastG = 1;
    bit          pv0 = 0, pv1 = 0, perr = 0;
    logic [31:0] pdata = 0;

    always @(negedge clk) begin
        bit          g0, g1, e0, e1, we, hit;
        logic [31:0] addr, wd;
        logic [3:0]  be;
        longint      a;
        int          w;
        e0 = pv0 && !rst;
        e1 = pv1 && !rst;
        checkOutput("model_rvalid0", 32'(m0_rvalid), 32'(e0));
        checkOutput("model_rvalid1", 32'(m1_rvalid), 32'(e1));
        checkOutput("model_err0", 32'(m0_err), 32'(e0 && perr));
        checkOutput("model_err1", 32'(m1_err), 32'(e1 && perr));
        checkOutput("model_rdata0", m0_rdata, e0 ? pdata : 32'h0);
        checkOutput("model_rdata1", m1_rdata, e1 ? pdata : 32'h0);

        g0 = 0; g1 = 0;
        if (!rst) begin
            if (m0_req && m1_req) begin
                g0 = (lastG == 1);
                g1 = !g0;
            end else begin
                g0 = m0_req;
                g1 = m1_req;
            end
        end
        checkOutput("model_gnt0", 32'(m0_gnt), 32'(g0));
        checkOutput("model_gnt1", 32'(m1_gnt), 32'(g1));

        we   = g1 ? m1_we : m0_we;
        addr = g1 ? m1_addr : m0_addr;
        wd   = g1 ? m1_wdata : m0_wdata;
        be   = g1 ? m1_be : m0_be;
        a    = longint'(addr);
        hit  = (a >= longint'(BASE)) && (a < longint'(BASE) + DP * 4);
        w    = hit ? int'((a - longint'(BASE)) / 4) : 0;
        checkOutput("model_ram_we", 32'(ram_we), 32'((g0 || g1) && hit && we));

        pv0 = 0; pv1 = 0; perr = 0; pdata = 0;
        if (rst) begin
            lastG = 1;
        end else if (g0 || g1) begin
            lastG = g1 ? 1 : 0;
            pv0   = g0;
            pv1   = g1;
            perr  = !hit;
            if (hit && we) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) refMem[w][8*b +: 8] = wd[8*b +: 8];
            end else if (hit) begin
                pdata = refMem[w];
            end
        end
    end

    // Drives one cycle of inputs just after the clock edge, then waits to sample.
    task automatic applyStimulus(input logic r,
                                 input logic q0, input logic w0, input logic [31:0] a0,
                                 input logic [31:0] d0, input logic [3:0] b0,
                                 input logic q1, input logic w1, input logic [31:0] a1,
                                 input logic [31:0] d1, input logic [3:0] b1);
        @(posedge clk);
        #1;
        rst = r;
        m0_req = q0; m0_we = w0; m0_addr = a0; m0_wdata = d0; m0_be = b0;
        m1_req = q1; m1_we = w1; m1_addr = a1; m1_wdata = d1; m1_be = b1;
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic randTxn(output logic w, output logic [31:0] a, output logic [31:0] d,
                           output logic [3:0] b);
        w = 1'($urandom_range(0, 1));
        d = $urandom;
        b = 4'($urandom);
        case ($urandom_range(0, 9))
            0:       a = BASE - 32'(4 * $urandom_range(1, 8));
            1:       a = BASE + 32'(DP * 4) + 32'($urandom_range(0, 63));
            default: a = BASE + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
        endcase
    endtask

    initial begin
        logic        q0, q1, w0, w1, r;
        logic [31:0] a0, a1, d0, d1;
        logic [3:0]  b0, b1;

        for (int i = 0; i < DP; i++) begin
            ramMem[i] = 32'h0;
            refMem[i] = 32'h0;
        end
        rst = 1'b1;
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0; m0_be = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_be = 0;

        // Requests during reset must not be granted.
        applyStimulus(1, 1, 1, BASE, 32'h1, 4'hF, 1, 1, BASE, 32'h2, 4'hF);
        checkOutput("reset_gnt0", 32'(m0_gnt), 0);
        checkOutput("reset_gnt1", 32'(m1_gnt), 0);
        checkOutput("reset_ram_we", 32'(ram_we), 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("reset_rvalid0", 32'(m0_rvalid), 0);
        checkOutput("reset_ram_addr", 32'(ram_addr), 0);

        // Write then read back on m0.
        applyStimulus(0, 1, 1, BASE + 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0);
        checkOutput("t1_wr_gnt", 32'(m0_gnt), 1);
        checkOutput("t1_wr_ram_addr", 32'(ram_addr), 4);
        applyStimulus(0, 1, 0, BASE + 32'h10, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t1_rd_gnt", 32'(m0_gnt), 1);
        checkOutput("t1_wr_rvalid", 32'(m0_rvalid), 1);
        idle();
        checkOutput("t1_rd_rvalid", 32'(m0_rvalid), 1);
        checkOutput("t1_rd_rdata", m0_rdata, 32'hDEADBEEF);
        checkOutput("t1_rd_err", 32'(m0_err), 0);

        // Partial byte write on m1.
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, BASE + 32'h40, 32'h11223344, 4'hF);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, BASE + 32'h40, 32'h0000AB00, 4'b0010);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, BASE + 32'h40, 0, 0);
        idle();
        checkOutput("t3_rdata", m1_rdata, 32'h1122AB44);

        // Both masters reading every cycle alternate, m0 first.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 1, 0, BASE + 32'h10, 0, 0, 1, 0, BASE + 32'h40, 0, 0);
            checkOutput("t2_gnt0", 32'(m0_gnt), 32'((i % 2) == 0));
            checkOutput("t2_gnt1", 32'(m1_gnt), 32'((i % 2) == 1));
            if (i > 0) checkOutput("t2_rvalid1", 32'(m1_rvalid), 32'((i % 2) == 0));
        end
        idle();
        checkOutput("t2_last_rdata1", m1_rdata, 32'h1122AB44);

        // Out-of-range accesses on both sides.
        applyStimulus(0, 1, 0, BASE + 32'(DP * 4), 0, 0, 1, 1, BASE - 32'h4, 32'hFFFFFFFF, 4'hF);
        checkOutput("t4_gnt0", 32'(m0_gnt), 1);
        checkOutput("t4_ram_we_a", 32'(ram_we), 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, BASE - 32'h4, 32'hFFFFFFFF, 4'hF);
        checkOutput("t4_gnt1", 32'(m1_gnt), 1);
        checkOutput("t4_ram_we_b", 32'(ram_we), 0);
        checkOutput("t4_err0", 32'(m0_err), 1);
        checkOutput("t4_rdata0", m0_rdata, 0);
        idle();
        checkOutput("t4_err1", 32'(m1_err), 1);
        checkOutput("t4_ram_last_word", ramMem[DP-1], 0);

        // Reset drops an in-flight m1 response and restores m0 priority.
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, BASE + 32'h10, 0, 0);
        checkOutput("t5_gnt1", 32'(m1_gnt), 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t5_no_rvalid1", 32'(m1_rvalid), 0);
        applyStimulus(0, 1, 0, BASE, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, BASE, 0, 0, 1, 0, BASE, 0, 0);
        checkOutput("t5_first_gnt0", 32'(m0_gnt), 1);
        idle();

        // Cross-master write then read of the same word.
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, BASE + 32'h20, 32'h5A5A5A5A, 4'hF);
        applyStimulus(0, 1, 0, BASE + 32'h20, 0, 0, 0, 0, 0, 0, 0);
        idle();
        checkOutput("t6_rdata0", m0_rdata, 32'h5A5A5A5A);

        // Random traffic; an ungranted request is held until accepted.
        q0 = 0; q1 = 0; w0 = 0; w1 = 0; a0 = 0; a1 = 0; d0 = 0; d1 = 0; b0 = 0; b1 = 0;
        for (int c = 0; c < 3000; c++) begin
            r = ($urandom_range(0, 99) == 0);
            if (r || !q0 || m0_gnt) begin
                q0 = ($urandom_range(0, 3) != 0);
                randTxn(w0, a0, d0, b0);
            end
            if (r || !q1 || m1_gnt) begin
                q1 = ($urandom_range(0, 3) != 0);
                randTxn(w1, a1, d1, b1);
            end
            applyStimulus(r, q0, w0, a0, d0, b0, q1, w1, a1, d1, b1);
        end
        idle();
        idle();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
